// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the e155 keypad scanner: scan FSM states,
// idle row/column pattern, key code lookup and column drive decode.
package e155_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Hex code printed on the key at (row, col) of the 4x4 pad
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            4'hF:    code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and display-side signals of the scanner, grouped as one bundle.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] columns;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (input rows, output columns, output key, output key_valid, output key_held);
    modport slave  (output rows, input columns, input key, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-stage, two-phase synchronizer for the asynchronous keypad rows.
// Each stage is a master flop on ph2 feeding a slave flop on ph1.
module sync2
    import e155_pkg::*;
(
    input  logic       ph1,
    input  logic       ph2,
    input  logic       reset,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] m1_q, s1_q, m2_q, s2_q;

    // Master halves capture on ph2; reset loads the idle (all released) pattern
    always_ff @(posedge ph2) begin
        if (!reset) begin
            m1_q <= COL_IDLE;
            m2_q <= COL_IDLE;
        end else begin
            m1_q <= d_i;
            m2_q <= s1_q;
        end
    end

    // Slave halves transfer on ph1
    always_ff @(posedge ph1) begin
        s1_q <= m1_q;
        s2_q <= m2_q;
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces a press
// and its release, and emits one hex code with a single-cycle valid pulse.
module keypad_scanner
    import e155_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 2
) (
    input logic                ph1,
    input logic                ph2,
    input logic                reset,
    keypad_scanner_if.master   kp
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int VW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [VW-1:0] DIV_MAX = VW'(SCAN_DIV - 1);
    localparam logic [VW-1:0] DIV_ONE = VW'(1);

    typedef struct packed {
        scan_state_t   state;
        logic [1:0]    col;
        logic [VW-1:0] div;
        logic [DW-1:0] deb;
        logic [1:0]    row;
        logic [3:0]    key;
        logic          valid;
        logic          held;
        logic [3:0]    columns;
    } regs_t;

    localparam regs_t RST_VAL = '{state: SCAN, col: 2'd0, div: '0, deb: '0, row: 2'd0,
                                  key: 4'h0, valid: 1'b0, held: 1'b0, columns: 4'b1110};

    logic [3:0] rows_s;
    logic       low_any_s;
    logic [1:0] low_row_s;
    regs_t      cur_q, mst_q, nxt_d;

    sync2 u_sync (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .d_i   (kp.rows),
        .q_o   (rows_s)
    );

    // Lowest pressed row wins when several rows read low
    always_comb begin
        low_any_s = 1'b1;
        low_row_s = 2'd0;
        casez (rows_s)
            4'b???0: low_row_s = 2'd0;
            4'b??01: low_row_s = 2'd1;
            4'b?011: low_row_s = 2'd2;
            4'b0111: low_row_s = 2'd3;
            default: low_any_s = 1'b0;
        endcase
    end

    // Next-state: scan rotation, press/release debounce, key capture
    always_comb begin
        nxt_d       = cur_q;
        nxt_d.valid = 1'b0;
        case (cur_q.state)
            SCAN: begin
                if (!low_any_s) begin
                    if (cur_q.div == DIV_MAX) begin
                        nxt_d.div = '0;
                        nxt_d.col = cur_q.col + 2'd1;
                    end else begin
                        nxt_d.div = cur_q.div + DIV_ONE;
                    end
                end else begin
                    nxt_d.state = DEBOUNCE;
                    nxt_d.row   = low_row_s;
                    nxt_d.deb   = DEB_ONE;
                end
            end
            DEBOUNCE: begin
                if (!low_any_s || (low_row_s != cur_q.row)) begin
                    nxt_d.state = SCAN;
                    nxt_d.div   = '0;
                    nxt_d.col   = cur_q.col + 2'd1;
                end else if (cur_q.deb == DEB_MAX) begin
                    nxt_d.state = HELD;
                    nxt_d.key   = keymap(cur_q.row, cur_q.col);
                    nxt_d.valid = 1'b1;
                    nxt_d.held  = 1'b1;
                end else begin
                    nxt_d.deb = cur_q.deb + DEB_ONE;
                end
            end
            HELD: begin
                if (rows_s[cur_q.row]) begin
                    nxt_d.state = RELEASE;
                    nxt_d.deb   = DEB_ONE;
                end else begin
                    nxt_d.held = 1'b1;
                end
            end
            RELEASE: begin
                if (!rows_s[cur_q.row]) begin
                    nxt_d.state = HELD;
                end else if (cur_q.deb == DEB_MAX) begin
                    nxt_d.state = SCAN;
                    nxt_d.div   = '0;
                    nxt_d.col   = cur_q.col + 2'd1;
                    nxt_d.held  = 1'b0;
                end else begin
                    nxt_d.deb = cur_q.deb + DEB_ONE;
                end
            end
            default: nxt_d = RST_VAL;
        endcase
        nxt_d.columns = col_drive(nxt_d.col);
    end

    // Master half of every state flop, with synchronous active-low reset
    always_ff @(posedge ph2) begin
        if (!reset) begin
            mst_q <= RST_VAL;
        end else begin
            mst_q <= nxt_d;
        end
    end

    // Slave half drives the registered outputs
    always_ff @(posedge ph1) begin
        cur_q <= mst_q;
    end

    assign kp.columns   = cur_q.columns;
    assign kp.key       = cur_q.key;
    assign kp.key_valid = cur_q.valid;
    assign kp.key_held  = cur_q.held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random row
// activity, compared every cycle against a behavioural keypad model.
module tb_keypad_scanner;

    localparam int DEB  = 4;
    localparam int SDIV = 2;
    localparam int P_SCAN = 0, P_CONFIRM = 1, P_HOLD = 2, P_REL = 3;

    logic ph1 = 1'b0;
    logic ph2 = 1'b0;
    logic reset;

    keypad_scanner_if kp();

    keypad_scanner #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .kp    (kp)
    );

    initial begin
        forever begin
            #1 ph1 = 1'b1;
            #2 ph1 = 1'b0;
            #3 ph2 = 1'b1;
            #2 ph2 = 1'b0;
            #2;
        end
    end

    // Reference model: what the keypad user should see, cycle by cycle
    int          m_col, m_div, m_phase, m_cnt, m_row;
    logic [3:0]  m_key;
    logic        m_valid, m_held;
    logic [3:0]  hist[$] = '{4'hF, 4'hF};
    logic [63:0] key_table = 64'h123A_456B_789C_E0FD;

    int checks = 0;
    int passed = 0;

    logic [9:0] dut_vec;
    assign dut_vec = {kp.columns, kp.key, kp.key_valid, kp.key_held};

    function automatic logic [9:0] exp_vec();
        logic [3:0] one = 4'b0001;
        return {~(one << m_col), m_key, m_valid, m_held};
    endfunction

    task automatic model_tick(input logic [3:0] r, input logic rst);
        logic [3:0] seen;
        int low;
        if (!rst) begin
            m_col = 0; m_div = 0; m_phase = P_SCAN; m_cnt = 0; m_row = 0;
            m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
            hist = '{4'hF, 4'hF};
        end else begin
            seen = hist.pop_front();
            hist.push_back(r);
            low = 4;
            for (int i = 3; i >= 0; i--) if (seen[i] == 1'b0) low = i;
            m_valid = 1'b0;
            case (m_phase)
                P_SCAN: begin
                    if (low == 4) begin
                        m_div++;
                        if (m_div >= SDIV) begin m_div = 0; m_col = (m_col + 1) % 4; end
                    end else begin
                        m_phase = P_CONFIRM; m_row = low; m_cnt = 1;
                    end
                end
                P_CONFIRM: begin
                    if (low != m_row) begin
                        m_phase = P_SCAN; m_div = 0; m_col = (m_col + 1) % 4;
                    end else if (m_cnt == DEB) begin
                        m_phase = P_HOLD; m_valid = 1'b1; m_held = 1'b1;
                        m_key = key_table[(15 - (m_row * 4 + m_col)) * 4 +: 4];
                    end else m_cnt++;
                end
                P_HOLD: if (seen[m_row]) begin m_phase = P_REL; m_cnt = 1; end
                default: begin
                    if (!seen[m_row]) m_phase = P_HOLD;
                    else if (m_cnt == DEB) begin
                        m_phase = P_SCAN; m_div = 0; m_col = (m_col + 1) % 4; m_held = 1'b0;
                    end else m_cnt++;
                end
            endcase
        end
    endtask

    // One scanner cycle: drive, let ph2 sample, then settle after the next ph1
    task automatic step(input logic [3:0] r, input logic rst);
        kp.rows = r;
        reset   = rst;
        @(posedge ph2);
        model_tick(r, rst);
        @(negedge ph1);
    endtask

    // Idle until a press driven now would be captured while column c is selected
    task automatic wait_col(input int c);
        int n = 0;
        while (!(m_phase == P_SCAN && hist[0] == 4'hF && hist[1] == 4'hF &&
                 ((m_col + (m_div + 2) / SDIV) % 4) == c) && n < 64) begin
            step(4'hF, 1'b1);
            n++;
        end
        if (n >= 64) begin
            checks++;
            $display("FAIL wait_col: column %0d never reached within 64 cycles", c);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b0);
            checks++;
            if (dut_vec !== {4'b1110, 4'h0, 1'b0, 1'b0})
                $display("FAIL reset_hold: got %b want %b", dut_vec, {4'b1110, 4'h0, 1'b0, 1'b0});
            else passed++;
        end
        for (int i = 0; i < 10; i++) begin
            step(4'hF, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reset_rotate: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        int pulse_at = -1;
        int pulses = 0;
        wait_col(0);
        for (int k = 0; k < 12; k++) begin
            step(4'b1101, 1'b1);
            if (kp.key_valid) begin pulses++; if (pulse_at < 0) pulse_at = k; end
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL clean_press: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (pulse_at !== DEB + 2 || pulses !== 1)
            $display("FAIL clean_latency: pulse step %0d count %0d, want step %0d count 1", pulse_at, pulses, DEB + 2);
        else passed++;
        checks++;
        if (kp.key !== 4'h4 || kp.key_held !== 1'b1)
            $display("FAIL clean_key: key %h held %b, want 4 1", kp.key, kp.key_held);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            step(4'hF, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL clean_release: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (kp.key_held !== 1'b0 || kp.key !== 4'h4)
            $display("FAIL clean_released: held %b key %h, want 0 4", kp.key_held, kp.key);
        else passed++;
    endtask

    task automatic test_press_bounce();
        int pulses = 0;
        wait_col(0);
        for (int k = 0; k < 20; k++) begin
            step((k < 6 && k % 2 == 1) ? 4'b1111 : 4'b1101, 1'b1);
            if (kp.key_valid) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL press_bounce: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (pulses !== 1 || kp.key_held !== 1'b1)
            $display("FAIL press_bounce_pulses: count %0d held %b, want 1 1", pulses, kp.key_held);
        else passed++;
        for (int k = 0; k < 12; k++) step(4'hF, 1'b1);
    endtask

    task automatic test_release_bounce();
        int pulses = 0;
        wait_col(1);
        for (int k = 0; k < 10; k++) step(4'b1110, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step((k < 2) ? 4'b1111 : 4'b1110, 1'b1);
            if (kp.key_valid) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL release_bounce: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (pulses !== 0 || kp.key_held !== 1'b1 || kp.key !== 4'h2)
            $display("FAIL release_bounce_state: pulses %0d held %b key %h, want 0 1 2", pulses, kp.key_held, kp.key);
        else passed++;
        for (int k = 0; k < 12; k++) step(4'hF, 1'b1);
    endtask

    task automatic test_multi_rows();
        wait_col(2);
        for (int k = 0; k < 10; k++) begin
            step(4'b0110, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL multi_rows: got %b want %b", dut_vec, exp_vec());
            else passed++;
        end
        checks++;
        if (kp.key !== 4'h3) $display("FAIL multi_rows_key: got %h want 3", kp.key);
        else passed++;
        for (int k = 0; k < 12; k++) step(4'hF, 1'b1);
    endtask

    task automatic test_corners();
        int         cr_row[4]  = '{0, 0, 3, 3};
        int         cr_col[4]  = '{0, 3, 0, 3};
        logic [3:0] cr_code[4] = '{4'h1, 4'hA, 4'hE, 4'hD};
        logic [3:0] pat;
        for (int i = 0; i < 4; i++) begin
            pat = 4'hF;
            pat[cr_row[i]] = 1'b0;
            wait_col(cr_col[i]);
            for (int k = 0; k < 10; k++) step(pat, 1'b1);
            checks++;
            if (kp.key !== cr_code[i] || kp.key_held !== 1'b1)
                $display("FAIL corner r%0dc%0d: key %h held %b, want %h 1", cr_row[i], cr_col[i], kp.key, kp.key_held, cr_code[i]);
            else passed++;
            for (int k = 0; k < 12; k++) step(4'hF, 1'b1);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pulses = 0;
        wait_col(1);
        for (int k = 0; k < 4; k++) step(4'b1011, 1'b1);
        step(4'hF, 1'b0);
        checks++;
        if (dut_vec !== {4'b1110, 4'h0, 1'b0, 1'b0})
            $display("FAIL reset_mid_debounce: got %b want %b", dut_vec, {4'b1110, 4'h0, 1'b0, 1'b0});
        else passed++;
        for (int k = 0; k < 10; k++) begin
            step(4'hF, 1'b1);
            if (kp.key_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0] pat;
        logic       rst;
        logic       prev_valid = 1'b0;
        int         len;
        for (int it = 0; it < 250; it++) begin
            pat = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < len; k++) begin
                step(pat, (k == 0) ? rst : 1'b1);
                checks++;
                if (dut_vec !== exp_vec()) $display("FAIL random it %0d: got %b want %b", it, dut_vec, exp_vec());
                else passed++;
                if (kp.key_valid && prev_valid) begin
                    checks++;
                    $display("FAIL random_double_pulse: key_valid high two cycles in a row (it %0d)", it);
                end
                prev_valid = kp.key_valid;
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        kp.rows = 4'hF;
        @(negedge ph1);
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_multi_rows();
        test_corners();
        test_reset_mid_debounce();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
